// File: rtl/ram_march_pkg.sv
// Shared types for the RAM march self-test sequencer.
package ram_march_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W0,
    R1,
    C1,
    R2,
    C2,
    FIN
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/ram_march_tester_if.sv
// Initiator/target view of the single-port RAM bus used by the march tester.
interface ram_march_tester_if #(
  parameter int unsigned ADDR_W = 1,
  parameter int unsigned DATA_W = 8
);
  logic              R_W_;
  logic [ADDR_W-1:0] ADDR_;
  logic [DATA_W-1:0] DATA_IN;
  logic [DATA_W-1:0] DATA_OUT;

  modport master (output R_W_, output ADDR_, output DATA_IN, input DATA_OUT);
  modport slave  (input R_W_, input ADDR_, input DATA_IN, output DATA_OUT);
endinterface

// File: rtl/march_addr_counter.sv
// Loadable up/down address counter that saturates at the end of its current direction.
module march_addr_counter
  import ram_march_pkg::*;
#(
  parameter int unsigned ADDR_W = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  input  logic              i_step,
  input  logic              i_dir,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_term
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  logic [ADDR_W-1:0] r_addr;

  // Terminal means the last address in whichever direction is being walked.
  always_comb begin
    o_term = (i_dir == DIR_UP) ? (r_addr == ADDR_MAX) : (r_addr == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_load_val;
    end else if (i_step && !o_term) begin
      r_addr <= (i_dir == DIR_UP) ? r_addr + ADDR_W'(1) : r_addr - ADDR_W'(1);
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/ram_march_tester.sv
// March-style BIST sequencer: background write, ascending read/invert, descending read-back check.
module ram_march_tester
  import ram_march_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 1,
  parameter int unsigned       DATA_W  = 8,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(8'hAA),
  parameter int unsigned       RD_LAT  = 1
) (
  input  logic                  CLK_,
  input  logic                  RST_,
  input  logic                  START_,
  ram_march_tester_if.master    ram,
  output logic                  BUSY_,
  output logic                  DONE_,
  output logic                  PASS_,
  output logic                  FAIL_,
  output logic [ADDR_W-1:0]     FAIL_ADDR_,
  output logic [DATA_W-1:0]     FAIL_DATA_
);

  localparam int unsigned       LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_e            r_state;
  logic [LAT_W-1:0]  r_lat;
  logic              r_rw;
  logic [DATA_W-1:0] r_din;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic              r_fail;
  logic [ADDR_W-1:0] r_fail_addr;
  logic [DATA_W-1:0] r_fail_data;

  logic              w_load;
  logic [ADDR_W-1:0] w_load_val;
  logic              w_step;
  logic              w_dir;
  logic [ADDR_W-1:0] w_addr;
  logic              w_term;
  logic              w_lat_done;
  logic              w_mismatch;

  march_addr_counter #(.ADDR_W(ADDR_W)) u_addr (
    .i_clk      (CLK_),
    .i_rst      (RST_),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_step     (w_step),
    .i_dir      (w_dir),
    .o_addr     (w_addr),
    .o_term     (w_term)
  );

  assign w_dir      = (r_state == C2) ? DIR_DOWN : DIR_UP;
  assign w_lat_done = (r_lat == LAT_W'(RD_LAT - 1));

  // Read-back compare is only meaningful in the two check states.
  always_comb begin
    w_mismatch = 1'b0;
    if (r_state == C1) begin
      w_mismatch = (ram.DATA_OUT != PATTERN);
    end else if (r_state == C2) begin
      w_mismatch = (ram.DATA_OUT != ~PATTERN);
    end
  end

  // Address sequencing: step after each write/check, reposition at phase boundaries.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    w_step     = 1'b0;
    case (r_state)
      IDLE: w_load = START_;
      W0:   if (w_term) w_load = 1'b1; else w_step = 1'b1;
      C1: begin
        if (w_term) begin
          w_load     = 1'b1;
          w_load_val = ADDR_MAX;
        end else begin
          w_step = 1'b1;
        end
      end
      C2:      w_step = !w_term;
      FIN:     w_load = 1'b1;
      default: w_load = 1'b0;
    endcase
  end

  always_ff @(posedge CLK_) begin
    if (RST_) begin
      r_state     <= IDLE;
      r_lat       <= '0;
      r_rw        <= 1'b0;
      r_din       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_rw  <= 1'b0;
          r_din <= '0;
          if (START_) begin
            r_state     <= W0;
            r_busy      <= 1'b1;
            r_rw        <= 1'b1;
            r_din       <= PATTERN;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
          end
        end
        W0: begin
          if (w_term) begin
            r_state <= R1;
            r_rw    <= 1'b0;
            r_din   <= '0;
            r_lat   <= '0;
          end
        end
        R1: begin
          if (w_lat_done) begin
            r_state <= C1;
            r_rw    <= 1'b1;
            r_din   <= ~PATTERN;
            r_lat   <= '0;
          end else begin
            r_lat <= r_lat + LAT_W'(1);
          end
        end
        C1: begin
          r_rw    <= 1'b0;
          r_din   <= '0;
          r_state <= w_term ? R2 : R1;
        end
        R2: begin
          if (w_lat_done) begin
            r_state <= C2;
            r_lat   <= '0;
          end else begin
            r_lat <= r_lat + LAT_W'(1);
          end
        end
        C2: begin
          if (w_term) begin
            r_state <= FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= !(r_fail || w_mismatch);
          end else begin
            r_state <= R2;
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      // Only the first mismatch of a run is recorded; the run continues regardless.
      if (w_mismatch) begin
        r_fail <= 1'b1;
        if (!r_fail) begin
          r_fail_addr <= w_addr;
          r_fail_data <= ram.DATA_OUT;
        end
      end
    end
  end

  assign ram.R_W_    = r_rw;
  assign ram.ADDR_   = w_addr;
  assign ram.DATA_IN = r_din;
  assign BUSY_       = r_busy;
  assign DONE_       = r_done;
  assign PASS_       = r_pass;
  assign FAIL_       = r_fail;
  assign FAIL_ADDR_  = r_fail_addr;
  assign FAIL_DATA_  = r_fail_data;

endmodule

// File: tb/tb_ram_march_tester.sv
// Bench for ram_march_tester: two instances (RD_LAT 1 and 2) each beside a behavioural 2x8 RAM.
module tb_ram_march_tester;

  localparam logic [7:0] PAT = 8'hAA;

  typedef struct packed {
    logic [0:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic       pass;
    logic       fail;
    logic [0:0] addr;
    logic [7:0] data;
    int         len;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic rst_a, start_a, busy_a, done_a, pass_a, fail_a;
  logic [0:0] faddr_a;
  logic [7:0] fdata_a;
  logic rst_b, start_b, busy_b, done_b, pass_b, fail_b;
  logic [0:0] faddr_b;
  logic [7:0] fdata_b;

  ram_march_tester_if #(.ADDR_W(1), .DATA_W(8)) if_a ();
  ram_march_tester_if #(.ADDR_W(1), .DATA_W(8)) if_b ();

  ram_march_tester #(.ADDR_W(1), .DATA_W(8), .PATTERN(PAT), .RD_LAT(1)) dut_a (
    .CLK_(clk), .RST_(rst_a), .START_(start_a), .ram(if_a),
    .BUSY_(busy_a), .DONE_(done_a), .PASS_(pass_a), .FAIL_(fail_a),
    .FAIL_ADDR_(faddr_a), .FAIL_DATA_(fdata_a)
  );

  ram_march_tester #(.ADDR_W(1), .DATA_W(8), .PATTERN(PAT), .RD_LAT(2)) dut_b (
    .CLK_(clk), .RST_(rst_b), .START_(start_b), .ram(if_b),
    .BUSY_(busy_b), .DONE_(done_b), .PASS_(pass_b), .FAIL_(fail_b),
    .FAIL_ADDR_(faddr_b), .FAIL_DATA_(fdata_b)
  );

  // RAM A: registered read, optional addr1 bit1 stuck-at-0 on the read path.
  logic [7:0] mem_a [2];
  logic [7:0] rd_a;
  bit         stuck_a = 1'b0;
  always @(posedge clk) begin
    if (if_a.R_W_ === 1'b1) mem_a[if_a.ADDR_] <= if_a.DATA_IN;
    rd_a <= (stuck_a && if_a.ADDR_ == 1'b1) ? (mem_a[if_a.ADDR_] & 8'hFD) : mem_a[if_a.ADDR_];
  end
  assign if_a.DATA_OUT = rd_a;

  // RAM B: read latency selectable between 1 and 2 cycles.
  logic [7:0] mem_b [2];
  logic [7:0] d1_b, d2_b;
  bit         lat2_b = 1'b1;
  always @(posedge clk) begin
    if (if_b.R_W_ === 1'b1) mem_b[if_b.ADDR_] <= if_b.DATA_IN;
    d1_b <= mem_b[if_b.ADDR_];
    d2_b <= d1_b;
  end
  assign if_b.DATA_OUT = lat2_b ? d2_b : d1_b;

  wr_t  exp_wr_a [$];
  res_t exp_res_a [$];
  res_t exp_res_b [$];
  int   busy_cnt_a = 0, busy_cnt_b = 0;
  int   done_cnt_a = 0, done_cnt_b = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ram_read(input logic [7:0] d, input int a, input bit stuck);
    return (stuck && a == 1) ? (d & 8'hFD) : d;
  endfunction

  // Reference march over a 2-entry memory.
  function automatic res_t model(input bit stuck, input int lat);
    res_t       r;
    logic [7:0] m [2];
    logic [7:0] rd;
    r.pass = 1'b0; r.fail = 1'b0; r.addr = '0; r.data = '0;
    r.len  = 2 + 2 * 2 * (lat + 1);
    for (int a = 0; a < 2; a++) m[a] = PAT;
    for (int a = 0; a < 2; a++) begin
      rd = ram_read(m[a], a, stuck);
      if (rd !== PAT) begin
        if (!r.fail) begin r.addr = 1'(a); r.data = rd; end
        r.fail = 1'b1;
      end
      m[a] = ~PAT;
    end
    for (int a = 1; a >= 0; a--) begin
      rd = ram_read(m[a], a, stuck);
      if (rd !== ~PAT) begin
        if (!r.fail) begin r.addr = 1'(a); r.data = rd; end
        r.fail = 1'b1;
      end
    end
    r.pass = !r.fail;
    return r;
  endfunction

  // Monitor A: write stream and end-of-test results against the scoreboard.
  always @(negedge clk) begin
    wr_t  w;
    res_t r;
    if (busy_a === 1'b1) busy_cnt_a++;
    if (if_a.R_W_ === 1'b1) begin
      check("a_wr_expected", 32'(exp_wr_a.size() != 0), 32'd1);
      if (exp_wr_a.size() != 0) begin
        w = exp_wr_a.pop_front();
        check("a_wr_addr", 32'(if_a.ADDR_), 32'(w.addr));
        check("a_wr_data", 32'(if_a.DATA_IN), 32'(w.data));
      end
    end
    if (done_a === 1'b1) begin
      done_cnt_a++;
      check("a_done_expected", 32'(exp_res_a.size() != 0), 32'd1);
      if (exp_res_a.size() != 0) begin
        r = exp_res_a.pop_front();
        check("a_busy_len", 32'(busy_cnt_a), 32'(r.len));
        check("a_busy_at_done", 32'(busy_a), 32'd0);
        check("a_pass", 32'(pass_a), 32'(r.pass));
        check("a_fail", 32'(fail_a), 32'(r.fail));
        check("a_fail_addr", 32'(faddr_a), 32'(r.addr));
        check("a_fail_data", 32'(fdata_a), 32'(r.data));
      end
      busy_cnt_a = 0;
    end
  end

  // Monitor B: end-of-test results only.
  always @(negedge clk) begin
    res_t r;
    if (busy_b === 1'b1) busy_cnt_b++;
    if (done_b === 1'b1) begin
      done_cnt_b++;
      check("b_done_expected", 32'(exp_res_b.size() != 0), 32'd1);
      if (exp_res_b.size() != 0) begin
        r = exp_res_b.pop_front();
        check("b_busy_len", 32'(busy_cnt_b), 32'(r.len));
        check("b_pass", 32'(pass_b), 32'(r.pass));
        check("b_fail", 32'(fail_b), 32'(r.fail));
      end
      busy_cnt_b = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_run_a(input bit stuck);
    wr_t w;
    for (int a = 0; a < 2; a++) begin w.addr = 1'(a); w.data = PAT;  exp_wr_a.push_back(w); end
    for (int a = 0; a < 2; a++) begin w.addr = 1'(a); w.data = ~PAT; exp_wr_a.push_back(w); end
    exp_res_a.push_back(model(stuck, 1));
  endtask

  task automatic pulse_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int target);
    for (int i = 0; i < 60 && done_cnt_a < target; i++) tick();
    check("a_done_timeout", 32'(done_cnt_a >= target), 32'd1);
  endtask

  task automatic wait_done_b(input int target);
    for (int i = 0; i < 60 && done_cnt_b < target; i++) tick();
    check("b_done_timeout", 32'(done_cnt_b >= target), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int d0;
    // Reset with START_ held: everything must come up cleared and idle.
    rst_a = 1'b1; start_a = 1'b1;
    rst_b = 1'b1; start_b = 1'b0;
    repeat (2) tick();
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_pass", 32'(pass_a), 32'd0);
    check("rst_fail", 32'(fail_a), 32'd0);
    check("rst_faddr", 32'(faddr_a), 32'd0);
    check("rst_fdata", 32'(fdata_a), 32'd0);
    check("rst_rw", 32'(if_a.R_W_), 32'd0);
    check("rst_addr", 32'(if_a.ADDR_), 32'd0);
    check("rst_din", 32'(if_a.DATA_IN), 32'd0);
    rst_a = 1'b0; start_a = 1'b0;
    rst_b = 1'b0;
    tick();
    check("rst_start_ignored", 32'(busy_a), 32'd0);

    // Good RAM, single run.
    expect_run_a(1'b0);
    pulse_a();
    check("a_busy_after_start", 32'(busy_a), 32'd1);
    wait_done_a(1);
    repeat (3) tick();
    check("a_pass_sticky", 32'(pass_a), 32'd1);

    // Stuck-at fault on addr1 bit1.
    stuck_a = 1'b1;
    expect_run_a(1'b1);
    pulse_a();
    wait_done_a(2);
    repeat (2) tick();
    check("a_fail_sticky", 32'(fail_a), 32'd1);
    stuck_a = 1'b0;

    // START_ pulsed mid-test must not restart or produce an extra DONE_.
    expect_run_a(1'b0);
    pulse_a();
    repeat (4) tick();
    pulse_a();
    wait_done_a(3);
    d0 = done_cnt_a;
    repeat (15) tick();
    check("a_single_done", 32'(done_cnt_a), 32'(d0));
    check("a_idle_after_mid_start", 32'(busy_a), 32'd0);

    // START_ held through FIN restarts after one IDLE cycle.
    expect_run_a(1'b0);
    expect_run_a(1'b0);
    start_a = 1'b1;
    tick();
    wait_done_a(5);
    start_a = 1'b0;
    check("a_idle_between_runs_len", 32'(exp_res_a.size()), 32'd0);
    repeat (12) tick();
    check("a_no_third_run", 32'(busy_a), 32'd0);

    // Reset during C1 aborts at once; a fresh run then completes cleanly.
    stuck_a = 1'b1;
    expect_run_a(1'b1);
    pulse_a();
    repeat (3) tick();
    check("a_in_c1_write", 32'(if_a.R_W_), 32'd1);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    check("a_abort_busy", 32'(busy_a), 32'd0);
    check("a_abort_rw", 32'(if_a.R_W_), 32'd0);
    check("a_abort_fail", 32'(fail_a), 32'd0);
    exp_wr_a.delete();
    exp_res_a.delete();
    busy_cnt_a = 0;
    stuck_a = 1'b0;
    tick();
    expect_run_a(1'b0);
    pulse_a();
    wait_done_a(6);

    // RD_LAT=2 instance against latency-2 then latency-1 RAM.
    lat2_b = 1'b1;
    exp_res_b.push_back(model(1'b0, 2));
    start_b = 1'b1; tick(); start_b = 1'b0;
    wait_done_b(1);
    tick();
    lat2_b = 1'b0;
    exp_res_b.push_back(model(1'b0, 2));
    start_b = 1'b1; tick(); start_b = 1'b0;
    wait_done_b(2);
    repeat (3) tick();

    check("a_scoreboard_drained", 32'(exp_wr_a.size() + exp_res_a.size()), 32'd0);
    check("b_scoreboard_drained", 32'(exp_res_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
